// File: rtl/mips_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_isa_pkg
// Brief    : MIPS opcode/function field constants and branch/jump classifier
//            shared by the decode queue predecoder and the ID control decoder.
// Revision : 1.0 - initial release
// ============================================================================
package mips_isa_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    function automatic logic [5:0] inst_opcode(input logic [31:0] inst);
        return inst[31:26];
    endfunction

    function automatic logic [5:0] inst_func(input logic [31:0] inst);
        return inst[5:0];
    endfunction

    // Any instruction that owns a delay slot.
    function automatic logic is_bj(input logic [31:0] inst);
        logic r_hit;
        r_hit = 1'b0;
        case (inst_opcode(inst))
            OP_REGIMM, OP_J, OP_JAL,
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: r_hit = 1'b1;
            OP_SPECIAL: r_hit = (inst_func(inst) == FN_JR) ||
                                (inst_func(inst) == FN_JALR);
            default:    r_hit = 1'b0;
        endcase
        return r_hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_predecode.sv
`default_nettype none
// ============================================================================
// Module   : mips_predecode
// Brief    : Combinational single-lane predecoder flagging branch/jump class.
// Revision : 1.0 - initial release
// ============================================================================
module mips_predecode
    import mips_isa_pkg::*;
(
    input  logic [31:0] inst,
    output logic        bj
);

    assign bj = is_bj(inst);

endmodule
`default_nettype wire

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : decode_queue
// Brief    : Circular fetch-to-ID instruction queue with branch/delay-slot
//            pairing at the head and full / keep-head flush.
// Revision : 1.0 - initial release
// ============================================================================
module decode_queue
    import mips_isa_pkg::*;
#(
    parameter  int FETCH_W = 2,
    parameter  int DEPTH   = 8,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         in_valid,
    input  logic [$clog2(FETCH_W+1)-1:0] in_count,
    input  logic [31:0]                  in_pc,
    input  logic [32*FETCH_W-1:0]        in_inst,
    input  logic [FETCH_W-1:0]           in_exc,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_pc,
    output logic [31:0]                  out_inst,
    output logic                         out_exc,
    output logic                         out_is_bj,
    input  logic                         flush,
    input  logic                         flush_keep_head,
    output logic [PTR_W:0]               count
);

    localparam logic [PTR_W:0]   C_DEPTH   = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   C_FETCH_W = (PTR_W+1)'(FETCH_W);
    localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   C_CNT_TWO = (PTR_W+1)'(2);
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

    logic [31:0]        r_inst [DEPTH];
    logic [31:0]        r_pc   [DEPTH];
    logic               r_exc  [DEPTH];
    logic               r_bj   [DEPTH];

    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W:0]     r_count;

    logic [FETCH_W-1:0] w_lane_bj;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [PTR_W:0]     w_push_n;
    logic [PTR_W:0]     w_pop_n;
    logic               w_head_bj;
    logic               w_head_exc;

    generate
        for (genvar g = 0; g < FETCH_W; g++) begin : g_predecode
            mips_predecode u_predecode (
                .inst (in_inst[32*g +: 32]),
                .bj   (w_lane_bj[g])
            );
        end
    endgenerate

    assign w_empty    = (r_count == '0);
    assign w_head_bj  = r_bj[r_rd_ptr];
    assign w_head_exc = r_exc[r_rd_ptr];

    assign in_ready   = (C_DEPTH - r_count) >= C_FETCH_W;

    // A branch at the head waits for its delay slot unless it already faulted.
    assign out_valid  = ~w_empty & (~w_head_bj | w_head_exc | (r_count >= C_CNT_TWO));

    assign w_push     = in_valid & in_ready & ~flush & (in_count != '0);
    assign w_pop      = out_valid & out_ready & ~flush;
    assign w_push_n   = w_push ? (PTR_W+1)'(in_count) : '0;
    assign w_pop_n    = w_pop ? C_CNT_ONE : '0;

    assign out_pc     = w_empty ? 32'd0 : r_pc[r_rd_ptr];
    assign out_inst   = w_empty ? 32'd0 : r_inst[r_rd_ptr];
    assign out_exc    = w_empty ? 1'b0  : w_head_exc;
    assign out_is_bj  = w_empty ? 1'b0  : w_head_bj;
    assign count      = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (i < int'(in_count)) begin
                    r_inst[r_wr_ptr + PTR_W'(i)] <= in_inst[32*i +: 32];
                    r_pc  [r_wr_ptr + PTR_W'(i)] <= in_pc + 32'(4*i);
                    r_exc [r_wr_ptr + PTR_W'(i)] <= in_exc[i];
                    r_bj  [r_wr_ptr + PTR_W'(i)] <= w_lane_bj[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            if (flush_keep_head && !w_empty) begin
                r_wr_ptr <= r_rd_ptr + C_PTR_ONE;
                r_count  <= C_CNT_ONE;
            end else begin
                r_rd_ptr <= r_wr_ptr;
                r_count  <= '0;
            end
        end else begin
            r_wr_ptr <= r_wr_ptr + w_push_n[PTR_W-1:0];
            r_rd_ptr <= r_rd_ptr + w_pop_n[PTR_W-1:0];
            r_count  <= r_count + w_push_n - w_pop_n;
        end
    end

    a_in_count_legal : assert property (@(posedge clk) disable iff (!resetn)
        in_valid |-> (int'(in_count) <= FETCH_W));

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_queue
// Brief    : Directed and randomized bench for decode_queue against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_queue;

    localparam int FETCH_W = 2;
    localparam int DEPTH   = 8;
    localparam int PTR_W   = 3;

    logic              clk = 1'b0;
    logic              resetn;
    logic              in_valid;
    logic [1:0]        in_count;
    logic [31:0]       in_pc;
    logic [63:0]       in_inst;
    logic [1:0]        in_exc;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [31:0]       out_inst;
    logic              out_exc;
    logic              out_is_bj;
    logic              flush;
    logic              flush_keep_head;
    logic [PTR_W:0]    count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic        bj;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    decode_queue #(.FETCH_W(FETCH_W), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .in_valid        (in_valid),
        .in_count        (in_count),
        .in_pc           (in_pc),
        .in_inst         (in_inst),
        .in_exc          (in_exc),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_inst        (out_inst),
        .out_exc         (out_exc),
        .out_is_bj       (out_is_bj),
        .flush           (flush),
        .flush_keep_head (flush_keep_head),
        .count           (count)
    );

    function automatic logic ref_bj(input logic [31:0] i);
        int op;
        int fn;
        op = int'(i[31:26]);
        fn = int'(i[5:0]);
        if (op == 1 || op == 2 || op == 3 || (op >= 4 && op <= 7)) return 1'b1;
        if (op == 0 && (fn == 8 || fn == 9)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] rand_inst();
        int ops [10] = '{0, 0, 1, 2, 3, 4, 5, 7, 8, 35};
        int fns [3]  = '{8, 9, 33};
        logic [31:0] r;
        int op;
        r  = $urandom;
        op = ops[$urandom_range(0, 9)];
        r[31:26] = 6'(op);
        if (op == 0) r[5:0] = 6'(fns[$urandom_range(0, 2)]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, compare, then advance the model.
    task automatic cyc(input logic v, input int n, input logic [31:0] pc,
                       input logic [63:0] ins, input logic [1:0] ex,
                       input logic rdy, input logic fl, input logic fk);
        logic exp_ready;
        logic exp_valid;
        logic do_push;
        logic do_pop;
        ent_t e;
        ent_t h;
        @(negedge clk);
        in_valid = v; in_count = 2'(n); in_pc = pc; in_inst = ins; in_exc = ex;
        out_ready = rdy; flush = fl; flush_keep_head = fk;
        #1;
        exp_ready = (DEPTH - q.size()) >= FETCH_W;
        exp_valid = 1'b0;
        if (q.size() != 0) exp_valid = !q[0].bj || q[0].exc || q.size() >= 2;
        chk("count", 64'(count), 64'(q.size()));
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        if (q.size() == 0) begin
            chk("empty_out", {out_pc, out_inst[29:0], out_exc, out_is_bj}, 64'd0);
        end else if (exp_valid) begin
            chk("out_pc", 64'(out_pc), 64'(q[0].pc));
            chk("out_inst", 64'(out_inst), 64'(q[0].inst));
            chk("out_exc", 64'(out_exc), 64'(q[0].exc));
            chk("out_is_bj", 64'(out_is_bj), 64'(q[0].bj));
        end
        do_push = v && exp_ready && !fl && n > 0;
        do_pop  = exp_valid && rdy && !fl;
        if (fl) begin
            if (fk && q.size() != 0) begin
                h = q[0];
                q.delete();
                q.push_back(h);
            end else begin
                q.delete();
            end
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                for (int k = 0; k < n; k++) begin
                    e.pc   = pc + 32'(4 * k);
                    e.inst = ins[32*k +: 32];
                    e.exc  = ex[k];
                    e.bj   = ref_bj(e.inst);
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 0, 32'd0, 64'd0, 2'b00, rdy, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        in_valid = 0; in_count = 0; in_pc = 0; in_inst = 0; in_exc = 0;
        out_ready = 0; flush = 0; flush_keep_head = 0;
        #22;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_out", {out_pc, out_inst[29:0], out_exc, out_is_bj}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Two-lane push, then drain in order.
        idle(1'b0);
        cyc(1'b1, 2, 32'hBFC00000, {32'h24020002, 32'h24010001}, 2'b00, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_pc", 64'(out_pc), 64'hBFC00000);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        chk("t1_drained", 64'(count), 64'd0);

        // JAL held until its slot arrives.
        cyc(1'b1, 1, 32'h00000100, {32'd0, 32'h0C000010}, 2'b00, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t2_held", 64'(out_valid), 64'd0);
        chk("t2_count", 64'(count), 64'd1);
        cyc(1'b1, 1, 32'h00000104, 64'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t2_valid", 64'(out_valid), 64'd1);
        chk("t2_bj", 64'(out_is_bj), 64'd1);
        idle(1'b1);
        idle(1'b1);

        // Faulting JAL is never held.
        cyc(1'b1, 1, 32'h00000200, {32'd0, 32'h0C000010}, 2'b01, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t3_valid", 64'(out_valid), 64'd1);
        chk("t3_exc", 64'(out_exc), 64'd1);
        chk("t3_count", 64'(count), 64'd1);
        idle(1'b1);

        // Fill across the pointer wrap, then push+pop at count 6.
        for (int k = 0; k < 4; k++)
            cyc(1'b1, 2, 32'h00001000 + 32'(8 * k),
                {32'h24000000 | 32'(2*k+1), 32'h24000000 | 32'(2*k)}, 2'b00, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t4_full_count", 64'(count), 64'd8);
        chk("t4_full_ready", 64'(in_ready), 64'd0);
        idle(1'b1);
        idle(1'b1);
        cyc(1'b1, 1, 32'h00001100, {32'd0, 32'h24001100}, 2'b00, 1'b1, 1'b0, 1'b0);
        settle();
        chk("t4_pushpop", 64'(count), 64'd6);
        for (int k = 0; k < 7; k++) idle(1'b1);

        // Pop BEQ, then keep-head flush with a dropped push.
        cyc(1'b1, 2, 32'h00000300, {32'h00000000, 32'h10220003}, 2'b00, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2, 32'h00000308, {32'h2403000B, 32'h2402000A}, 2'b00, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        cyc(1'b1, 2, 32'h00000400, {32'h24050000, 32'h24040000}, 2'b00, 1'b1, 1'b1, 1'b1);
        settle();
        chk("t5_count", 64'(count), 64'd1);
        chk("t5_pc", 64'(out_pc), 64'h00000304);
        idle(1'b1);
        idle(1'b0);

        // Asynchronous reset between edges.
        cyc(1'b1, 2, 32'h00000500, {32'h24070000, 32'h24060000}, 2'b00, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2, 32'h00000508, {32'h24090000, 32'h24080000}, 2'b00, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1, 32'h00000510, {32'h00000000, 32'h240A0000}, 2'b00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk("t6_pre", 64'(count), 64'd5);
        resetn = 1'b0;
        in_valid = 0; in_count = 0;
        #1;
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_ready", 64'(in_ready), 64'd1);
        q.delete();
        @(negedge clk);
        resetn = 1'b1;

        // Randomized traffic.
        for (int t = 0; t < 600; t++) begin
            logic [63:0] ins;
            logic [1:0]  ex;
            logic        fl;
            ins = {rand_inst(), rand_inst()};
            ex  = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
            fl  = ($urandom_range(0, 19) == 0);
            cyc(($urandom_range(0, 3) != 0), int'($urandom_range(0, 2)),
                {$urandom, 2'b00}, ins, ex, ($urandom_range(0, 2) != 0),
                fl, 1'($urandom_range(0, 1)));
        end
        idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_queue.md
Name: decode_queue

Overview:
Instruction buffer between fetch and the ID-stage control decoder, generalised to a FETCH_W-wide fetch packet and a DEPTH-entry circular queue. Each pushed instruction is predecoded for branch/jump class. The queue holds back a branch/jump at the head until its delay slot is also buffered, so ID always sees a branch together with its slot. It supports a full flush and a keep-head flush for a taken branch whose delay slot is already queued.

Parameters:
FETCH_W, 2, instructions accepted per push (1..4)
DEPTH, 8, queue entries; power of two, DEPTH >= 2*FETCH_W
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
in_valid  input  1  fetch packet offered
in_count  input  $clog2(FETCH_W+1)  number of valid instructions in packet, lowest lanes first
in_pc  input  32  PC of lane 0; lane i PC = in_pc + 4*i
in_inst  input  32*FETCH_W  lane i at bits [32*i+31:32*i]
in_exc  input  FETCH_W  per-lane fetch exception (AdEL/TLB)
in_ready  output  1  space for a full packet
out_valid  output  1  head presentable to ID
out_ready  input  1  ID consumes head
out_pc  output  32  head PC
out_inst  output  32  head instruction
out_exc  output  1  head fetch exception
out_is_bj  output  1  head is branch/jump (delay slot guaranteed queued when out_valid)
flush  input  1  discard entries
flush_keep_head  input  1  qualifies flush: retain only the head entry
count  output  PTR_W+1  current occupancy

Behaviour:
- Reset (resetn=0, async): rd_ptr=wr_ptr=0, count=0, out_valid=0, in_ready=1, out_pc/out_inst/out_exc/out_is_bj=0. Storage contents are not reset.
- in_ready = (DEPTH - count) >= FETCH_W. It is combinational from registered count and never depends on out_ready.
- Push fires when in_valid & in_ready & ~flush.
  - Writes lanes 0..in_count-1 at wr_ptr..wr_ptr+in_count-1, modulo DEPTH.
  - in_count=0 is a no-op. in_count>FETCH_W is illegal (assertion).
- Predecode per lane at push; stored bit bj=1 for:
  - opcode 000010 (J), 000011 (JAL), 000001 (REGIMM), 000100..000111 (BEQ/BNE/BLEZ/BGTZ);
  - opcode 000000 with func 001000 (JR) or 001001 (JALR).
- Latency: a pushed entry is visible at the head no earlier than the next cycle. There is no bypass.
- out_valid = (count!=0) & (~head_bj | head_exc | count>=2). A faulting head is never held.
- Pop fires when out_valid & out_ready & ~flush. rd_ptr advances by 1 mod DEPTH.
- Push and pop may fire in the same cycle: count_next = count + pushed - popped.
- Outputs out_* read the head entry combinationally. They are 0 when count==0 and don't-care when out_valid=0 with count!=0.
- Flush has priority over push and pop in the same cycle; both are dropped.
  - flush & ~flush_keep_head: rd_ptr=wr_ptr, count=0.
  - flush & flush_keep_head & count>=1: wr_ptr=rd_ptr+1, count=1. The head (delay slot, after the branch was popped) survives.
  - flush & flush_keep_head & count==0: acts as full flush.
- Pointer wrap: rd_ptr and wr_ptr are PTR_W bits and wrap naturally. Full/empty come from count only (count==DEPTH full, 0 empty).
- flush_keep_head without flush is ignored.

Decomposition:
- Package mips_isa_pkg: opcode/func localparams (OP_SPECIAL, OP_REGIMM, OP_J, OP_JAL, OP_BEQ..OP_BGTZ, FN_JR, FN_JALR) plus a function is_bj(inst). The control decoder also adopts this package.
- One sub-module, mips_predecode: combinational, 32-bit inst -> bj. Instantiated FETCH_W times in a generate loop.

Test Plan:
1. Reset then push in_count=2, in_pc=0xBFC00000, insts 0x24010001/0x24020002.
   - Next cycle: out_valid=1, out_pc=0xBFC00000.
   - Pops give PCs 0xBFC00000, 0xBFC00004; count returns to 0.
2. Push in_count=1 with JAL (0x0C000010) alone.
   - out_valid stays 0 with count=1.
   - Push slot 0x00000000: next cycle out_valid=1, out_is_bj=1.
3. Same JAL alone with in_exc[0]=1 -> out_valid=1, out_exc=1 immediately, count=1.
4. Fill to DEPTH=8 with 4 pushes of 2, out_ready=0 -> in_ready=0 once count>=7.
   - Pop+push same cycle at count=6 -> count stays 6.
   - wr_ptr wraps to 0 correctly: PCs remain in order.
5. Queue holds BEQ+slot+2 more (count=4). Pop BEQ; next cycle flush=1 & flush_keep_head=1 -> count=1, head = slot PC.
   - A push in the flush cycle is dropped.
6. Assert resetn=0 mid-stream with count=5, asynchronously between edges -> count=0, out_valid=0 before the next clk edge; in_ready=1.
